traffic_phase_ctrl: RTL and testbench

Parametrised successor to the two-road fixed-cycle light controller. Drives N_ROADS approaches in round-robin order with green, yellow and all-red clearance phases. Adds demand-based phase skipping, green extension, a manual force mode and a flashing-yellow maintenance mode. Outputs per-road lamp drives and a two-digit BCD countdown for the active phase; it replaces the counter/sequencer cluster at the top of the controller.

---
 rtl/traffic_pkg.sv | 24 ++
 rtl/traffic_phase_ctrl_sec_tick_gen.sv | 34 +++
 rtl/traffic_phase_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encoding, display constants and BCD helper
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_GREEN   = 3'd0,
        PH_YELLOW  = 3'd1,
        PH_ALL_RED = 3'd2,
        PH_FORCE   = 3'd3,
        PH_FLASH   = 3'd4
    } phase_e;

    // Digit code that leaves a seven-segment position dark.
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Binary 0..99 to {tens, units} BCD.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 7'd10);
        units = 4'(v % 7'd10);
        return {tens, units};
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_sec_tick_gen.sv
// rtl/traffic_phase_ctrl_sec_tick_gen.sv - seconds prescaler with synchronous clear
//   clk_i       : system clock
//   clr_i       : synchronous clear; restarts the current second from zero
//   sec_pulse_o : one-cycle pulse on the last tick of every second
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic clk_i,
    input  logic clr_i,
    output logic sec_pulse_o
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Depends on the count only, so the FSM can derive clr_i from this pulse
    // without forming a combinational loop.
    assign sec_pulse_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || sec_pulse_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - round-robin traffic phase sequencer with demand, force and flash modes
//   clock       : system clock, all state changes on the rising edge
//   R           : synchronous active-high reset
//   sensor      : per-road demand, level-sensitive
//   force_en    : manual hold request for force_road
//   force_road  : road held green while force_en=1; out-of-range values are ignored
//   flash_en    : maintenance flashing-yellow request
//   green       : one-hot green lamps
//   yellow      : yellow lamps
//   active_road : road owning the current phase
//   time_h/l    : BCD tens/units of the remaining seconds (blank while forced)
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_ROADS       = 2,
    parameter int GREEN_SEC     = 30,
    parameter int YELLOW_SEC    = 3,
    parameter int EXT_SEC       = 10,
    parameter int TICKS_PER_SEC = 1
) (
    input  logic                       clock,
    input  logic                       R,
    input  logic [N_ROADS-1:0]         sensor,
    input  logic                       force_en,
    input  logic [$clog2(N_ROADS)-1:0] force_road,
    input  logic                       flash_en,
    output logic [N_ROADS-1:0]         green,
    output logic [N_ROADS-1:0]         yellow,
    output logic [$clog2(N_ROADS)-1:0] active_road,
    output logic [3:0]                 time_l,
    output logic [3:0]                 time_h
);

    localparam int RW = $clog2(N_ROADS);
    localparam logic [6:0]  GREEN_T    = 7'(GREEN_SEC);
    localparam logic [6:0]  YELLOW_T   = 7'(YELLOW_SEC);
    localparam logic [6:0]  EXT_T      = 7'(EXT_SEC);
    localparam logic [RW:0] ROAD_LIMIT = (RW + 1)'(N_ROADS);
    localparam logic [7:0]  RESET_BCD  = bin_to_bcd(GREEN_T);

    function automatic logic [N_ROADS-1:0] onehot(input logic [RW-1:0] r);
        return {{(N_ROADS - 1){1'b0}}, 1'b1} << r;
    endfunction

    function automatic logic [RW-1:0] road_after(input logic [RW-1:0] cur);
        int idx;
        idx = int'(cur) + 1;
        if (idx >= N_ROADS) idx = idx - N_ROADS;
        return RW'(idx);
    endfunction

    // First road after cur (with wrap) that has demand; falls back to cur+1.
    // Scanning offsets from far to near lets the nearest hit win.
    function automatic logic [RW-1:0] next_road(input logic [RW-1:0] cur,
                                                 input logic [N_ROADS-1:0] dem);
        int idx;
        logic [RW-1:0] res;
        res = road_after(cur);
        for (int i = N_ROADS - 1; i >= 1; i--) begin
            idx = int'(cur) + i;
            if (idx >= N_ROADS) idx = idx - N_ROADS;
            if (dem[RW'(idx)]) res = RW'(idx);
        end
        return res;
    endfunction

    phase_e              state_q, state_d;
    logic [6:0]          rem_q, rem_d;
    logic [6:0]          ext_q, ext_d;
    logic [RW-1:0]       act_q, act_d;
    logic [RW-1:0]       nxt_q, nxt_d;
    logic                flash_q, flash_d;
    logic [N_ROADS-1:0]  green_q, green_d;
    logic [N_ROADS-1:0]  yellow_q, yellow_d;
    logic [7:0]          time_q, time_d;

    logic sec_pulse;
    logic force_ok;
    logic extend;

    // A fresh second starts on every phase entry so phases last whole seconds.
    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk_i      (clock),
        .clr_i      (R || (state_d != state_q)),
        .sec_pulse_o(sec_pulse)
    );

    assign force_ok = force_en && ({1'b0, force_road} < ROAD_LIMIT);
    assign extend   = sensor[act_q]
                   && ((sensor & ~onehot(act_q)) == '0)
                   && (ext_q < EXT_T);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ext_d   = ext_q;
        act_d   = act_q;
        nxt_d   = nxt_q;
        flash_d = flash_q;
        if (force_ok) begin
            state_d = PH_FORCE;
            act_d   = force_road;
        end else if (state_q == PH_FORCE) begin
            if (flash_en) begin
                state_d = PH_FLASH;
                flash_d = 1'b1;
                rem_d   = '0;
            end else begin
                state_d = PH_GREEN;
                rem_d   = GREEN_T;
                ext_d   = '0;
            end
        end else if (flash_en) begin
            if (state_q != PH_FLASH) begin
                state_d = PH_FLASH;
                flash_d = 1'b1;
                rem_d   = '0;
            end else if (sec_pulse) begin
                flash_d = ~flash_q;
            end
        end else begin
            case (state_q)
                PH_GREEN: begin
                    if (sec_pulse) begin
                        if (rem_q > 7'd1) begin
                            rem_d = rem_q - 7'd1;
                        end else if (extend) begin
                            ext_d = ext_q + 7'd1;
                        end else begin
                            state_d = PH_YELLOW;
                            rem_d   = YELLOW_T;
                            nxt_d   = next_road(act_q, sensor);
                        end
                    end
                end
                PH_YELLOW: begin
                    if (sec_pulse) begin
                        if (rem_q > 7'd1) begin
                            rem_d = rem_q - 7'd1;
                        end else begin
                            state_d = PH_ALL_RED;
                            rem_d   = 7'd1;
                        end
                    end
                end
                PH_ALL_RED: begin
                    if (sec_pulse) begin
                        state_d = PH_GREEN;
                        act_d   = nxt_q;
                        rem_d   = GREEN_T;
                        ext_d   = '0;
                    end
                end
                PH_FLASH: begin
                    state_d = PH_ALL_RED;
                    rem_d   = 7'd1;
                    nxt_d   = road_after(act_q);
                end
                default: begin
                    state_d = PH_GREEN;
                    rem_d   = GREEN_T;
                    ext_d   = '0;
                end
            endcase
        end
    end

    // Lamp and display values are decoded from the next state and then
    // registered, so the outputs never glitch.
    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        time_d   = bin_to_bcd(rem_d);
        case (state_d)
            PH_GREEN:  green_d  = onehot(act_d);
            PH_YELLOW: yellow_d = onehot(act_d);
            PH_FORCE: begin
                green_d = onehot(act_d);
                time_d  = {BCD_BLANK, BCD_BLANK};
            end
            PH_FLASH:  yellow_d = {N_ROADS{flash_d}};
            default: begin
                green_d  = '0;
                yellow_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (R) begin
            state_q  <= PH_GREEN;
            rem_q    <= GREEN_T;
            ext_q    <= '0;
            act_q    <= '0;
            nxt_q    <= '0;
            flash_q  <= 1'b0;
            green_q  <= onehot('0);
            yellow_q <= '0;
            time_q   <= RESET_BCD;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            ext_q    <= ext_d;
            act_q    <= act_d;
            nxt_q    <= nxt_d;
            flash_q  <= flash_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            time_q   <= time_d;
        end
    end

    assign green       = green_q;
    assign yellow      = yellow_q;
    assign active_road = act_q;
    assign time_h      = time_q[7:4];
    assign time_l      = time_q[3:0];

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed scoreboard bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

    logic       clock;
    logic       r2, r3;
    logic [1:0] sensor2, green2, yellow2;
    logic       force_en2, force_road2, flash_en2, active2;
    logic [3:0] tl2, th2;
    logic [2:0] sensor3, green3, yellow3;
    logic       force_en3, flash_en3;
    logic [1:0] force_road3, active3;
    logic [3:0] tl3, th3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        bit          d3;
        logic [26:0] exp;
    } sb_t;
    sb_t sb[$];

    traffic_phase_ctrl #(.N_ROADS(2), .GREEN_SEC(5), .YELLOW_SEC(2), .EXT_SEC(3), .TICKS_PER_SEC(2)) dut2 (
        .clock(clock), .R(r2), .sensor(sensor2), .force_en(force_en2), .force_road(force_road2),
        .flash_en(flash_en2), .green(green2), .yellow(yellow2), .active_road(active2),
        .time_l(tl2), .time_h(th2)
    );

    traffic_phase_ctrl #(.N_ROADS(3), .GREEN_SEC(5), .YELLOW_SEC(2), .EXT_SEC(3), .TICKS_PER_SEC(2)) dut3 (
        .clock(clock), .R(r3), .sensor(sensor3), .force_en(force_en3), .force_road(force_road3),
        .flash_en(flash_en3), .green(green3), .yellow(yellow3), .active_road(active3),
        .time_l(tl3), .time_h(th3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic expect_out(input string tag, input bit d3, input logic [7:0] g,
                              input logic [7:0] y, input logic [2:0] a, input logic [7:0] t);
        sb_t e;
        e.tag = tag;
        e.d3  = d3;
        e.exp = {g, y, a, t};
        sb.push_back(e);
    endtask

    task automatic tick();
        sb_t e;
        logic [26:0] o;
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.d3) o = {5'b0, green3, 5'b0, yellow3, 1'b0, active3, th3, tl3};
            else      o = {6'b0, green2, 6'b0, yellow2, 2'b0, active2, th2, tl2};
            checks++;
            assert (o === e.exp)
            else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic reset2();
        r2 = 1'b1;
        expect_out("d2_reset", 0, 8'h01, 8'h00, 3'd0, 8'h05);
        tick();
        r2 = 1'b0;
    endtask

    task automatic reset3();
        r3 = 1'b1;
        expect_out("d3_reset", 1, 8'h01, 8'h00, 3'd0, 8'h05);
        tick();
        r3 = 1'b0;
    endtask

    initial begin
        r2 = 1'b1; sensor2 = '0; force_en2 = 1'b0; force_road2 = 1'b0; flash_en2 = 1'b0;
        r3 = 1'b1; sensor3 = '0; force_en3 = 1'b0; force_road3 = '0;   flash_en3 = 1'b0;
        tick();

        // Plain cycle without demand: green0, yellow0, all-red, green1.
        reset2();
        for (int k = 1; k <= 16; k++) begin
            if (k <= 9)       expect_out("s1_green0", 0, 8'h01, 8'h00, 3'd0, bcd(5 - k / 2));
            else if (k <= 13) expect_out("s1_yellow0", 0, 8'h00, 8'h01, 3'd0, bcd(2 - (k - 10) / 2));
            else if (k <= 15) expect_out("s1_allred", 0, 8'h00, 8'h00, 3'd0, 8'h01);
            else              expect_out("s1_green1", 0, 8'h02, 8'h00, 3'd1, 8'h05);
            tick();
        end

        // Demand on road 2 only: road 1 is skipped.
        sensor3 = 3'b100;
        reset3();
        for (int k = 1; k <= 16; k++) begin
            if (k == 10) expect_out("s2_yellow0", 1, 8'h00, 8'h01, 3'd0, 8'h02);
            if (k == 14) expect_out("s2_allred", 1, 8'h00, 8'h00, 3'd0, 8'h01);
            if (k == 15) expect_out("s2_allred_hold", 1, 8'h00, 8'h00, 3'd0, 8'h01);
            if (k == 16) expect_out("s2_green2", 1, 8'h04, 8'h00, 3'd2, 8'h05);
            tick();
            if (k == 10) sensor3 = 3'b000;
        end

        // Lone demand on the active road: three extension seconds.
        sensor2 = 2'b01;
        reset2();
        for (int k = 1; k <= 16; k++) begin
            if (k == 10) expect_out("s3_ext_first", 0, 8'h01, 8'h00, 3'd0, 8'h01);
            if (k == 15) expect_out("s3_ext_last", 0, 8'h01, 8'h00, 3'd0, 8'h01);
            if (k == 16) expect_out("s3_ext_done", 0, 8'h00, 8'h01, 3'd0, 8'h02);
            tick();
        end

        // Demand appearing on the other road cuts the extension short.
        reset2();
        for (int k = 1; k <= 18; k++) begin
            if (k == 11) expect_out("s3_mid_ext", 0, 8'h01, 8'h00, 3'd0, 8'h01);
            if (k == 12) expect_out("s3_cut_ext", 0, 8'h00, 8'h01, 3'd0, 8'h02);
            if (k == 18) expect_out("s3_green1", 0, 8'h02, 8'h00, 3'd1, 8'h05);
            tick();
            if (k == 11) sensor2 = 2'b11;
        end
        sensor2 = 2'b00;

        // Force during yellow, then release into a full green.
        reset2();
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) expect_out("s4_yellow0", 0, 8'h00, 8'h01, 3'd0, 8'h02);
            tick();
        end
        force_en2 = 1'b1; force_road2 = 1'b1;
        expect_out("s4_force", 0, 8'h02, 8'h00, 3'd1, 8'hFF);
        tick();
        expect_out("s4_force_hold", 0, 8'h02, 8'h00, 3'd1, 8'hFF);
        tick();
        force_en2 = 1'b0;
        for (int k = 13; k <= 23; k++) begin
            if (k == 13) expect_out("s4_release", 0, 8'h02, 8'h00, 3'd1, 8'h05);
            if (k == 14) expect_out("s4_release_hold", 0, 8'h02, 8'h00, 3'd1, 8'h05);
            if (k == 15) expect_out("s4_count", 0, 8'h02, 8'h00, 3'd1, 8'h04);
            if (k == 22) expect_out("s4_last_sec", 0, 8'h02, 8'h00, 3'd1, 8'h01);
            if (k == 23) expect_out("s4_yellow1", 0, 8'h00, 8'h02, 3'd1, 8'h02);
            tick();
        end

        // Flash toggling, reset mid-flash, then flash release.
        reset2();
        flash_en2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            expect_out("s5_flash", 0, 8'h00, (k == 3 || k == 4) ? 8'h00 : 8'h03, 3'd0, 8'h00);
            tick();
        end
        r2 = 1'b1;
        expect_out("s5_reset_mid_flash", 0, 8'h01, 8'h00, 3'd0, 8'h05);
        tick();
        r2 = 1'b0;
        expect_out("s5_reflash", 0, 8'h00, 8'h03, 3'd0, 8'h00);
        tick();
        flash_en2 = 1'b0;
        expect_out("s5_allred", 0, 8'h00, 8'h00, 3'd0, 8'h01);
        tick();
        expect_out("s5_allred_hold", 0, 8'h00, 8'h00, 3'd0, 8'h01);
        tick();
        expect_out("s5_next_green", 0, 8'h02, 8'h00, 3'd1, 8'h05);
        tick();

        // Out-of-range force ignored; force beats flash; flash after release.
        force_en3 = 1'b1; force_road3 = 2'd3;
        reset3();
        expect_out("s6_bad_force", 1, 8'h01, 8'h00, 3'd0, 8'h05);
        tick();
        expect_out("s6_bad_force_count", 1, 8'h01, 8'h00, 3'd0, 8'h04);
        tick();
        flash_en3 = 1'b1; force_road3 = 2'd2;
        expect_out("s6_force_wins", 1, 8'h04, 8'h00, 3'd2, 8'hFF);
        tick();
        force_en3 = 1'b0;
        expect_out("s6_flash_after", 1, 8'h00, 8'h07, 3'd2, 8'h00);
        tick();
        expect_out("s6_flash_hold", 1, 8'h00, 8'h07, 3'd2, 8'h00);
        tick();
        expect_out("s6_flash_toggle", 1, 8'h00, 8'h00, 3'd2, 8'h00);
        tick();
        flash_en3 = 1'b0;
        expect_out("s6_allred", 1, 8'h00, 8'h00, 3'd2, 8'h01);
        tick();
        tick();
        expect_out("s6_wrap_green0", 1, 8'h01, 8'h00, 3'd0, 8'h05);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
